// File: rtl/cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : cmd_decoder
// Purpose  : Byte-stream command decoder for short (1-byte) and long
//            (opcode + 4 little-endian argument bytes) commands.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_stb_i,
    output logic        soft_reset_o,
    output logic        run_o,
    output logic        id_o,
    output logic        xctrl_o,
    output logic        trg_we_o,
    output logic [1:0]  trg_sel_o,
    output logic [1:0]  trg_stg_o,
    output logic [31:0] trg_data_o,
    output logic [23:0] div_o,
    output logic [15:0] read_cnt_o,
    output logic [15:0] delay_cnt_o,
    output logic [7:0]  flags_o,
    output logic        cfg_upd_o
);

    localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ARG  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       opc_q, opc_d;
    logic [23:0]      arg_q, arg_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic        soft_q, soft_d, run_q, run_d, id_q, id_d, xctrl_q, xctrl_d;
    logic        trg_we_q, trg_we_d, upd_q, upd_d;
    logic [1:0]  trg_sel_q, trg_sel_d, trg_stg_q, trg_stg_d;
    logic [31:0] trg_data_q, trg_data_d;
    logic [23:0] div_q, div_d;
    logic [15:0] rd_q, rd_d, dl_q, dl_d;
    logic [7:0]  flags_q, flags_d;

    // The 4th argument byte is used straight from the input, not stored.
    logic [31:0] w_arg;
    assign w_arg = {rx_data_i, arg_q};

    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        arg_d      = arg_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        soft_d     = 1'b0;
        run_d      = 1'b0;
        id_d       = 1'b0;
        trg_we_d   = 1'b0;
        upd_d      = 1'b0;
        xctrl_d    = xctrl_q;
        trg_sel_d  = trg_sel_q;
        trg_stg_d  = trg_stg_q;
        trg_data_d = trg_data_q;
        div_d      = div_q;
        rd_d       = rd_q;
        dl_d       = dl_q;
        flags_d    = flags_q;

        case (state_q)
            S_IDLE: begin
                if (rx_stb_i) begin
                    if (rx_data_i[7]) begin
                        opc_d   = rx_data_i;
                        cnt_d   = 2'd0;
                        tmo_d   = '0;
                        state_d = S_ARG;
                    end else begin
                        case (rx_data_i)
                            8'h00: begin
                                soft_d  = 1'b1;
                                xctrl_d = 1'b0;
                            end
                            8'h01:   run_d   = 1'b1;
                            8'h02:   id_d    = 1'b1;
                            8'h11:   xctrl_d = 1'b0;
                            8'h13:   xctrl_d = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            S_ARG: begin
                if (rx_stb_i) begin
                    tmo_d = '0;
                    if (cnt_q == 2'd3) begin
                        state_d = S_IDLE;
                        cnt_d   = 2'd0;
                        if (opc_q[7:4] == 4'hC && opc_q[1:0] != 2'b11) begin
                            trg_we_d   = 1'b1;
                            trg_stg_d  = opc_q[3:2];
                            trg_sel_d  = opc_q[1:0];
                            trg_data_d = w_arg;
                        end else begin
                            case (opc_q)
                                8'h80: begin
                                    div_d = w_arg[23:0];
                                    upd_d = 1'b1;
                                end
                                8'h81: begin
                                    rd_d  = w_arg[15:0];
                                    dl_d  = w_arg[31:16];
                                    upd_d = 1'b1;
                                end
                                8'h82: begin
                                    flags_d = w_arg[7:0];
                                    upd_d   = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end else begin
                        arg_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
                        cnt_d = cnt_q + 2'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // A byte arriving in this same cycle would have won instead.
                    state_d = S_IDLE;
                    tmo_d   = '0;
                    cnt_d   = 2'd0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            opc_q      <= 8'h00;
            arg_q      <= 24'h0;
            cnt_q      <= 2'd0;
            tmo_q      <= '0;
            soft_q     <= 1'b0;
            run_q      <= 1'b0;
            id_q       <= 1'b0;
            xctrl_q    <= 1'b0;
            trg_we_q   <= 1'b0;
            upd_q      <= 1'b0;
            trg_sel_q  <= 2'd0;
            trg_stg_q  <= 2'd0;
            trg_data_q <= 32'h0;
            div_q      <= 24'h0;
            rd_q       <= 16'h0;
            dl_q       <= 16'h0;
            flags_q    <= 8'h0;
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            arg_q      <= arg_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            soft_q     <= soft_d;
            run_q      <= run_d;
            id_q       <= id_d;
            xctrl_q    <= xctrl_d;
            trg_we_q   <= trg_we_d;
            upd_q      <= upd_d;
            trg_sel_q  <= trg_sel_d;
            trg_stg_q  <= trg_stg_d;
            trg_data_q <= trg_data_d;
            div_q      <= div_d;
            rd_q       <= rd_d;
            dl_q       <= dl_d;
            flags_q    <= flags_d;
        end
    end

    assign soft_reset_o = soft_q;
    assign run_o        = run_q;
    assign id_o         = id_q;
    assign xctrl_o      = xctrl_q;
    assign trg_we_o     = trg_we_q;
    assign trg_sel_o    = trg_sel_q;
    assign trg_stg_o    = trg_stg_q;
    assign trg_data_o   = trg_data_q;
    assign div_o        = div_q;
    assign read_cnt_o   = rd_q;
    assign delay_cnt_o  = dl_q;
    assign flags_o      = flags_q;
    assign cfg_upd_o    = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_decoder
// Purpose  : Directed and randomized checks of cmd_decoder against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_decoder;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb;
    logic [7:0]  data;
    logic        soft_reset_o, run_o, id_o, xctrl_o, trg_we_o, cfg_upd_o;
    logic [1:0]  trg_sel_o, trg_stg_o;
    logic [31:0] trg_data_o;
    logic [23:0] div_o;
    logic [15:0] read_cnt_o, delay_cnt_o;
    logic [7:0]  flags_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i        (clk),
        .rst_in       (rst_n),
        .rx_data_i    (data),
        .rx_stb_i     (stb),
        .soft_reset_o (soft_reset_o),
        .run_o        (run_o),
        .id_o         (id_o),
        .xctrl_o      (xctrl_o),
        .trg_we_o     (trg_we_o),
        .trg_sel_o    (trg_sel_o),
        .trg_stg_o    (trg_stg_o),
        .trg_data_o   (trg_data_o),
        .div_o        (div_o),
        .read_cnt_o   (read_cnt_o),
        .delay_cnt_o  (delay_cnt_o),
        .flags_o      (flags_o),
        .cfg_upd_o    (cfg_upd_o)
    );

    // Reference model: pending command kept as an opcode plus a byte queue.
    bit        m_busy;
    bit [7:0]  m_op;
    bit [7:0]  m_bytes[$];
    int        m_gap;
    bit        m_soft, m_run, m_id, m_xctrl, m_we, m_upd;
    bit [1:0]  m_sel, m_stg;
    bit [31:0] m_data;
    bit [23:0] m_div;
    bit [15:0] m_rd, m_dl;
    bit [7:0]  m_flags;

    task automatic model_edge(input bit r, input bit s, input bit [7:0] d);
        bit [31:0] arg;
        m_soft = 0; m_run = 0; m_id = 0; m_we = 0; m_upd = 0;
        if (!r) begin
            m_busy = 0; m_bytes.delete(); m_gap = 0; m_xctrl = 0;
            m_sel = 0; m_stg = 0; m_data = 0; m_div = 0;
            m_rd = 0; m_dl = 0; m_flags = 0;
        end else if (!m_busy) begin
            if (s && d >= 8'h80) begin
                m_busy = 1; m_op = d; m_bytes.delete(); m_gap = 0;
            end else if (s) begin
                if (d == 8'h00) begin m_soft = 1; m_xctrl = 0; end
                if (d == 8'h01) m_run = 1;
                if (d == 8'h02) m_id = 1;
                if (d == 8'h11) m_xctrl = 0;
                if (d == 8'h13) m_xctrl = 1;
            end
        end else if (s) begin
            m_bytes.push_back(d);
            m_gap = 0;
            if (m_bytes.size() == 4) begin
                arg = m_bytes[0] + (m_bytes[1] << 8) + (m_bytes[2] << 16) + (m_bytes[3] << 24);
                m_busy = 0;
                if (m_op / 16 == 12 && m_op % 4 != 3) begin
                    m_we = 1; m_stg = 2'((m_op / 4) % 4); m_sel = 2'(m_op % 4); m_data = arg;
                end else if (m_op == 8'h80) begin
                    m_div = 24'(arg % (1 << 24)); m_upd = 1;
                end else if (m_op == 8'h81) begin
                    m_rd = 16'(arg % 65536); m_dl = 16'(arg / 65536); m_upd = 1;
                end else if (m_op == 8'h82) begin
                    m_flags = 8'(arg % 256); m_upd = 1;
                end
            end
        end else begin
            m_gap++;
            if (m_gap == TMO) m_busy = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("soft_reset", 32'(soft_reset_o), 32'(m_soft));
        chk("run",        32'(run_o),        32'(m_run));
        chk("id",         32'(id_o),         32'(m_id));
        chk("xctrl",      32'(xctrl_o),      32'(m_xctrl));
        chk("trg_we",     32'(trg_we_o),     32'(m_we));
        chk("trg_sel",    32'(trg_sel_o),    32'(m_sel));
        chk("trg_stg",    32'(trg_stg_o),    32'(m_stg));
        chk("trg_data",   trg_data_o,        m_data);
        chk("div",        32'(div_o),        32'(m_div));
        chk("read_cnt",   32'(read_cnt_o),   32'(m_rd));
        chk("delay_cnt",  32'(delay_cnt_o),  32'(m_dl));
        chk("flags",      32'(flags_o),      32'(m_flags));
        chk("cfg_upd",    32'(cfg_upd_o),    32'(m_upd));
    endtask

    task automatic step(input bit r, input bit s, input bit [7:0] d);
        rst_n = r; stb = s; data = d;
        @(posedge clk);
        model_edge(r, s, d);
        #1;
        check_all();
    endtask

    task automatic send(input bit [7:0] d);
        step(1, 1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 8'h00);
    endtask

    bit [7:0] pick[14];

    initial begin
        pick = '{8'h00, 8'h01, 8'h02, 8'h11, 8'h13, 8'h80, 8'h81,
                 8'h82, 8'hC0, 8'hC5, 8'hCB, 8'hCF, 8'h83, 8'hFF};

        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        chk("rst_xctrl", 32'(xctrl_o), 32'h0);
        chk("rst_div",   32'(div_o),   32'h0);
        chk("rst_data",  trg_data_o,   32'h0);
        idle(2);

        send(8'h01); chk("d_run_pulse", 32'(run_o), 32'h1);
        send(8'h13); chk("d_run_end", 32'(run_o), 32'h0);
        chk("d_xoff", 32'(xctrl_o), 32'h1);
        idle(1);

        send(8'hC5); send(8'h78); send(8'h56); send(8'h34);
        chk("d_trg_early", 32'(trg_we_o), 32'h0);
        send(8'h12);
        chk("d_trg_we",   32'(trg_we_o),  32'h1);
        chk("d_trg_stg",  32'(trg_stg_o), 32'h1);
        chk("d_trg_sel",  32'(trg_sel_o), 32'h1);
        chk("d_trg_data", trg_data_o,     32'h12345678);
        idle(1);
        chk("d_trg_we_end", 32'(trg_we_o), 32'h0);
        chk("d_trg_hold",   trg_data_o,    32'h12345678);

        send(8'h81); send(8'h10); send(8'h00); send(8'h20); send(8'h00);
        chk("d_rdcnt", 32'(read_cnt_o),  32'h0010);
        chk("d_dlcnt", 32'(delay_cnt_o), 32'h0020);
        chk("d_upd81", 32'(cfg_upd_o),   32'h1);
        send(8'h80); send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
        chk("d_div_ff", 32'(div_o), 32'hFFFFFF);

        send(8'h80); send(8'h01); idle(TMO);
        send(8'h02);
        chk("d_tmo_id",  32'(id_o),      32'h1);
        chk("d_tmo_upd", 32'(cfg_upd_o), 32'h0);
        chk("d_tmo_div", 32'(div_o),     32'hFFFFFF);

        send(8'h80); send(8'h01); idle(TMO - 1);
        send(8'h02); send(8'h03); send(8'h04);
        chk("d_late_byte_div", 32'(div_o),     32'h030201);
        chk("d_late_byte_upd", 32'(cfg_upd_o), 32'h1);

        send(8'h82); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        chk("d_flags0", 32'(flags_o), 32'h0);
        chk("d_no_soft", 32'(soft_reset_o), 32'h0);
        send(8'h13);
        for (int i = 0; i < 5; i++) begin
            send(8'h00);
            chk("d_soft_pulse", 32'(soft_reset_o), 32'h1);
        end
        chk("d_soft_xon",  32'(xctrl_o), 32'h0);
        chk("d_soft_keep", 32'(div_o),   32'h030201);

        send(8'h80); send(8'hAA); send(8'hBB);
        step(0, 0, 8'h00);
        send(8'h02);
        chk("d_rst_id",  32'(id_o),  32'h1);
        chk("d_rst_div", 32'(div_o), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 1) step(0, 0, 8'h00);
            else if (r < 4) idle(int'($urandom_range(TMO - 2, TMO + 1)));
            else if (r < 30) step(1, 0, 8'($urandom));
            else if (r < 75) send(pick[$urandom_range(0, 13)]);
            else send(8'($urandom));
        end

        stb = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
